// File: rtl/regfile_mp_sb.sv
// Multi-ported integer register file (NRD read / NWR write-back ports) with
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_mp_sb #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int RSLEN    = $clog2(NUM_REGS),
  parameter int NRD      = 4,
  parameter int NWR      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*RSLEN-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wb_e,
  input  logic [NWR*RSLEN-1:0] wb_addr,
  input  logic [NWR*XLEN-1:0]  wb_data,
  input  logic                 iss_e,
  input  logic [RSLEN-1:0]     iss_addr,
  output logic                 iss_ok,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic                 wr_conflict
);

  logic [XLEN-1:0]     rf [NUM_REGS];
  logic [NWR-1:0]      we;
  logic                iss_hit;
  logic                conflict_nxt;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      we[j] = wb_e[j] & (wb_addr[j*RSLEN +: RSLEN] != '0);
    end
  end

  // Read side: later write ports override earlier ones, register 0 forced to zero
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [RSLEN-1:0] ra;
    logic [XLEN-1:0]  data_c;
    logic             hit_c;

    always_comb begin
      ra     = rd_addr[i*RSLEN +: RSLEN];
      data_c = rf[ra];
      hit_c  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wb_addr[j*RSLEN +: RSLEN] == ra)) begin
          data_c = wb_data[j*XLEN +: XLEN];
          hit_c  = 1'b1;
        end
      end
      if (ra == '0) data_c = '0;
      rd_data[i*XLEN +: XLEN] = data_c;
      rd_busy[i]              = busy_vec[ra] & ~hit_c;
    end
  end

  // Issue / scoreboard next state: flush > issue set > write-back clear > hold
  always_comb begin
    iss_hit      = 1'b0;
    conflict_nxt = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wb_addr[j*RSLEN +: RSLEN] == iss_addr)) iss_hit = 1'b1;
      for (int k = j + 1; k < NWR; k++) begin
        if (we[j] && we[k] &&
            (wb_addr[j*RSLEN +: RSLEN] == wb_addr[k*RSLEN +: RSLEN]))
          conflict_nxt = 1'b1;
      end
    end

    iss_ok = iss_e & ~flush & ((iss_addr == '0) | ~busy_vec[iss_addr] | iss_hit);

    busy_nxt = busy_vec;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_nxt[wb_addr[j*RSLEN +: RSLEN]] = 1'b0;
    end
    if (iss_ok && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // State update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
      busy_vec    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) rf[wb_addr[j*RSLEN +: RSLEN]] <= wb_data[j*XLEN +: XLEN];
      end
      busy_vec    <= busy_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: inputs change on the falling edge,
// outputs are checked mid-cycle, well away from the rising edge.
module tb_regfile_mp_sb;
  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int RSLEN    = 5;
  localparam int NRD      = 4;
  localparam int NWR      = 2;

  logic                 clk;
  logic                 rst;
  logic [NRD*RSLEN-1:0] rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wb_e;
  logic [NWR*RSLEN-1:0] wb_addr;
  logic [NWR*XLEN-1:0]  wb_data;
  logic                 iss_e;
  logic [RSLEN-1:0]     iss_addr;
  logic                 iss_ok;
  logic                 flush;
  logic [NUM_REGS-1:0]  busy_vec;
  logic                 wr_conflict;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp_sb #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .RSLEN(RSLEN), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb_e(wb_e), .wb_addr(wb_addr), .wb_data(wb_data), .iss_e(iss_e),
    .iss_addr(iss_addr), .iss_ok(iss_ok), .flush(flush), .busy_vec(busy_vec),
    .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rdp(input int i);
    return rd_data[i*XLEN +: XLEN];
  endfunction

  task automatic idle();
    wb_e = '0; wb_addr = '0; wb_data = '0;
    iss_e = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic rd_all(input logic [RSLEN-1:0] a);
    for (int i = 0; i < NRD; i++) rd_addr[i*RSLEN +: RSLEN] = a;
  endtask

  task automatic wb(input int p, input logic [RSLEN-1:0] a, input logic [XLEN-1:0] d);
    wb_e[p] = 1'b1;
    wb_addr[p*RSLEN +: RSLEN] = a;
    wb_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic [RSLEN-1:0] a);
    iss_e = 1'b1;
    iss_addr = a;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0;
    idle();

    // 1. reset state, then basic write and read-back on all ports
    @(negedge clk);
    rd_all(5'd5);
    #1;
    check("rst_rd_data", rd_data[XLEN-1:0] | rd_data[2*XLEN-1:XLEN] | rdp(2) | rdp(3), 32'h0);
    check("rst_busy_vec", busy_vec, 32'h0);
    check("rst_wr_conflict", {31'h0, wr_conflict}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wb(0, 5'd5, 32'hDEADBEEF);
    #1;
    check("bypass_r5", rdp(0), 32'hDEADBEEF);
    step();
    #1;
    for (int i = 0; i < NRD; i++) check($sformatf("rd_r5_p%0d", i), rdp(i), 32'hDEADBEEF);

    // 2. register 0 stays zero and never busy
    step();
    rd_all(5'd0);
    wb(1, 5'd0, 32'h1234);
    issue(5'd0);
    #1;
    check("r0_bypass", rdp(0) | rdp(1) | rdp(2) | rdp(3), 32'h0);
    check("iss_ok_r0", {31'h0, iss_ok}, 32'h1);
    step();
    #1;
    check("r0_busy_vec", busy_vec, 32'h0);
    check("r0_rd", rdp(3), 32'h0);

    // 3. dual write to one register: highest port wins, conflict flagged for one cycle
    step();
    rd_addr[2*RSLEN +: RSLEN] = 5'd7;
    wb(0, 5'd7, 32'h11);
    wb(1, 5'd7, 32'h22);
    #1;
    check("conf_bypass_p2", rdp(2), 32'h22);
    step();
    rd_all(5'd7);
    #1;
    check("conf_flag", {31'h0, wr_conflict}, 32'h1);
    check("conf_rf7", rdp(0), 32'h22);
    step();
    #1;
    check("conf_clear", {31'h0, wr_conflict}, 32'h0);

    // 4. issue, stall on busy, write-back resolves with concurrent reissue
    step();
    issue(5'd3);
    #1;
    check("iss_r3_ok", {31'h0, iss_ok}, 32'h1);
    step();
    rd_all(5'd3);
    issue(5'd3);
    #1;
    check("busy_r3", busy_vec, 32'h8);
    check("iss_r3_stall", {31'h0, iss_ok}, 32'h0);
    check("rd_busy_r3", {28'h0, rd_busy}, 32'hF);
    step();
    rd_all(5'd3);
    wb(0, 5'd3, 32'h55);
    issue(5'd3);
    #1;
    check("stall_no_change", busy_vec, 32'h8);
    check("iss_wb_ok", {31'h0, iss_ok}, 32'h1);
    check("iss_wb_rd_busy", {28'h0, rd_busy}, 32'h0);
    check("iss_wb_rd_data", rdp(1), 32'h55);
    step();
    #1;
    check("busy_r3_kept", busy_vec, 32'h8);
    check("rf3", rdp(2), 32'h55);

    // 5. flush clears all busy bits, blocks issue, but write still lands
    step(); issue(5'd1);
    step(); issue(5'd2);
    step(); issue(5'd9);
    step();
    #1;
    check("busy_multi", busy_vec, 32'h20E);
    rd_all(5'd9);
    flush = 1'b1;
    issue(5'd4);
    wb(0, 5'd9, 32'h9);
    #1;
    check("flush_iss_ok", {31'h0, iss_ok}, 32'h0);
    step();
    #1;
    check("flush_busy", busy_vec, 32'h0);
    check("flush_rf9", rdp(0), 32'h9);

    // 6. asynchronous reset between edges discards in-flight writes/issues
    step();
    wb(0, 5'd10, 32'hAA);
    wb(1, 5'd11, 32'hBB);
    issue(5'd12);
    step();
    rd_addr[0*RSLEN +: RSLEN] = 5'd10;
    rd_addr[1*RSLEN +: RSLEN] = 5'd11;
    rd_addr[2*RSLEN +: RSLEN] = 5'd12;
    rd_addr[3*RSLEN +: RSLEN] = 5'd13;
    wb(0, 5'd13, 32'hCC);
    issue(5'd14);
    #1;
    check("pre_rst_r10", rdp(0), 32'hAA);
    check("pre_rst_busy", busy_vec, 32'h1000);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_r10", rdp(0), 32'h0);
    check("async_rst_r11", rdp(1), 32'h0);
    check("async_rst_busy", busy_vec, 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("rst_no_commit_r13", rdp(3), 32'h0);
    check("rst_no_commit_busy", busy_vec, 32'h0);
    rst = 1'b1;
    step();
    #1;
    check("post_rst_r13", rdp(3), 32'h0);
    check("post_rst_wr_conflict", {31'h0, wr_conflict}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Multi-ported integer register file with a per-register scoreboard. It is the parametrised successor of the single-write, dual-read register file. It supports NRD read ports and NWR write-back ports, with same-cycle write-to-read bypass on every read port. It also tracks a busy bit per architectural register so decode can detect RAW/WAW hazards. It sits between decode/issue (read and issue side) and the write-back stage of the pipeline.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
XLEN, 32, data width in bits.
RSLEN, `CLOG2(NUM_REGS), register address width.
NRD, 4, number of read ports (minimum 1).
NWR, 2, number of write-back ports (minimum 1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-low (asserts when 0).
rd_addr  input  NRD*RSLEN  read addresses; port i uses slice [i*RSLEN +: RSLEN].
rd_data  output  NRD*XLEN  read data per port (combinational).
rd_busy  output  NRD  busy status of each read register after bypass (combinational).
wb_e  input  NWR  write enable per write port.
wb_addr  input  NWR*RSLEN  write addresses.
wb_data  input  NWR*XLEN  write data.
iss_e  input  1  issue request: mark iss_addr as pending producer.
iss_addr  input  RSLEN  destination register of the issuing instruction.
iss_ok  output  1  issue accepted this cycle (combinational).
flush  input  1  clear all busy bits (pipeline flush).
busy_vec  output  NUM_REGS  registered scoreboard state.
wr_conflict  output  1  registered flag: two write ports targeted the same register.

Behaviour:
- Reset (rst==0, asynchronous): all registers = 0, busy_vec = 0, wr_conflict = 0. Every output is then a function of zeroed state, so rd_data = bypass or 0.
- Effective write enable: we[j] = wb_e[j] & (wb_addr[j] != 0). Writes to register 0 are ignored. Register 0 always reads 0 and is never busy.
- Write: on posedge clk, each we[j] writes wb_data[j] to rf[wb_addr[j]]. If several enabled ports share an address, the highest port index wins.
- wr_conflict: registered 1 in the cycle after any two enabled ports write the same non-zero address; registered 0 otherwise. It is a diagnostic only and has no effect on the write.
- Read bypass, 0 cycle latency: rd_data[i] = wb_data[j] for the highest j with we[j] & (wb_addr[j]==rd_addr[i]); otherwise rf[rd_addr[i]]. Address 0 always gives 0.
- rd_busy[i] = busy_vec[rd_addr[i]] & ~(any we[j] matching rd_addr[i]). A same-cycle write-back resolves the hazard.
- Issue: iss_ok = iss_e & ~flush & (iss_addr==0 | ~busy_vec[iss_addr] | any we[j] matching iss_addr).
  - If iss_ok and iss_addr != 0, busy_vec[iss_addr] is 1 next cycle.
  - Issue to register 0 is accepted and changes nothing.
  - iss_e with iss_ok==0 is a stall: no state change, and the requester holds its request.
- Busy clear: each we[j] clears busy_vec[wb_addr[j]] next cycle.
- Priority per bit, highest first: flush (clear all) > accepted issue set > write-back clear > hold. Issue and write-back to the same register in the same cycle leaves busy=1 (new producer owns it).
- Flush does not cancel register writes in the same cycle; the data still lands.
- Register array writes are not gated by busy: a write-back to a non-busy register still updates data.
- Reset mid-operation: any in-flight write or issue in the reset cycle is discarded.

Test Plan:
1. Reset with rst=0 -> every rd_data=0, busy_vec=0, wr_conflict=0. Release, write r5=0xDEADBEEF via port 0 -> next cycle reading r5 on every port returns 0xDEADBEEF.
2. Write r0=0x1234 via port 1 -> reading r0 returns 0 on all ports. busy_vec[0] stays 0 even after iss_e with iss_addr=0 (iss_ok=1).
3. Same cycle: port0 writes r7=0x11, port1 writes r7=0x22, read port 2 addresses r7 -> rd_data[2]=0x22 combinationally. Next cycle rf[7]=0x22 and wr_conflict=1; the following idle cycle wr_conflict=0.
4. Issue r3 -> busy_vec[3]=1 next cycle. Then iss_e to r3 -> iss_ok=0. Then write-back r3=0x55 with concurrent iss_e r3 -> iss_ok=1, rd_busy=0, rd_data=0x55; busy_vec[3] stays 1.
5. Busy r1,r2,r9. Assert flush with iss_e to r4 and a write r9=0x9 -> iss_ok=0, all busy_vec=0 next cycle, rf[9]=0x9.
6. Drive writes and issues every cycle, then pull rst low asynchronously between edges -> outputs go to reset values immediately, with no write committed at the following edge.
